gh_gray_ptr: RTL

//   Binary-to-Gray pointer generator: an up-counter that keeps a binary count and a

---
 rtl/gh_gray_ptr.sv | 91 +++++++++
 1 files changed

// File: rtl/gh_gray_ptr.sv
// gh_gray_ptr: binary up-counter with a registered Gray-coded copy.
// It is the source side of a Gray pointer crossing, such as FIFO read/write pointers.
// Optional feature macro GH_GRAY_PTR_SYNC_EN adds three things:
//   - a 2-flop synchronizer for the far-domain Gray pointer,
//   - a Gray-to-binary conversion of that pointer,
//   - a registered level, equal to (bin - far_bin) mod 2**size.
module gh_gray_ptr #(
   parameter int unsigned size = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            load,
   input  logic [size-1:0] load_val,
   input  logic            inc,
`ifdef GH_GRAY_PTR_SYNC_EN
   input  logic [size-1:0] far_gray,
   output logic [size-1:0] far_bin,
   output logic [size-1:0] level,
`endif
   output logic [size-1:0] bin,
   output logic [size-1:0] gray,
   output logic            tc,
   output logic            wrap
);

   localparam logic [size-1:0] all_ones = '1;

   logic [size-1:0] bin_next_c;
   logic            wrap_next_c;

   // Next pointer value and wrap detection; priority clr > load > inc > hold
   always_comb begin
      bin_next_c  = bin;
      wrap_next_c = 1'b0;
      if (clr) begin
         bin_next_c = '0;
      end else if (load) begin
         bin_next_c = load_val;
      end else if (inc) begin
         bin_next_c  = bin + size'(1);
         wrap_next_c = (bin == all_ones);
      end
   end

   // Pointer registers; gray and tc are derived from bin_next so they never lag bin
   always_ff @(posedge clk) begin
      if (rst) begin
         bin  <= '0;
         gray <= '0;
         tc   <= 1'b0;
         wrap <= 1'b0;
      end else begin
         bin  <= bin_next_c;
         gray <= bin_next_c ^ (bin_next_c >> 1);
         tc   <= (bin_next_c == all_ones);
         wrap <= wrap_next_c;
      end
   end

`ifdef GH_GRAY_PTR_SYNC_EN
   logic [size-1:0] s1;
   logic [size-1:0] s2;
   logic [size-1:0] far_bin_c;

   // Gray-to-binary of the synchronized far pointer
   always_comb begin
      far_bin_c = '0;
      far_bin_c[size-1] = s2[size-1];
      for (int i = int'(size) - 2; i >= 0; i--) begin
         far_bin_c[i] = far_bin_c[i+1] ^ s2[i];
      end
   end

   // Two-flop synchronizer, converted far pointer and occupancy level; clr leaves these alone
   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         far_bin <= '0;
         level   <= '0;
      end else begin
         s1      <= far_gray;
         s2      <= s1;
         far_bin <= far_bin_c;
         level   <= bin - far_bin;
      end
   end
`endif

endmodule
